mem32_arbiter: RTL and testbench

// - Two-requester round-robin arbiter and sequencer in front of mem32 (16-byte array, 32-bit word port).
// - Latches one request, bounds-checks the address and drives a single mem32 wr or rd strobe.
// - Captures read data and returns a one-cycle ack, or err, to the granted requester.
// - Integration: mem32.rst is active-high, so it is tied to ~rst_n at the parent.

---
 rtl/mem32_ctrl_pkg.sv | 18 +
 rtl/rr_arb2.sv | 22 ++
 rtl/mem32_arbiter.sv | 140 ++++++++++++++
 tb/tb_mem32_arbiter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem32_ctrl_pkg.sv
// Shared types and constants for the mem32 arbiter/sequencer and its round-robin picker.
// Pure declarations; no latency or flow control of its own.
package mem32_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_t;

  // Highest legal start address: a 4-byte word starting here ends at byte 15.
  localparam int unsigned MAX_ADDR = 12;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin pick; zero latency.
// No backpressure: a grant is offered whenever any request is high, the caller decides when to take it.
module rr_arb2
  import mem32_ctrl_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       gnt_id,
  output logic       gnt_vld
);

  always_comb begin
    gnt_vld = |req;
    gnt_id  = REQ0;
    if (req == 2'b11) begin
      gnt_id = ~last_grant;
    end else if (req[1]) begin
      gnt_id = REQ1;
    end
  end

endmodule

// File: rtl/mem32_arbiter.sv
// Two-requester round-robin sequencer for mem32: write ack at T+2, read ack at T+3, range err at T+1.
// Requesters hold req until their ack/err pulse; one IDLE bubble separates transactions.
module mem32_arbiter
  import mem32_ctrl_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 4,
  parameter int MAX_ADDR = mem32_ctrl_pkg::MAX_ADDR
) (
  input  logic              Clk,
  input  logic              rst_n,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_ack,
  output logic              r0_err,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_ack,
  output logic              r1_err,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic              mem_wr,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_valid
);

  localparam logic [ADDR_W-1:0] MAX_A = ADDR_W'(MAX_ADDR);

  state_t            state_q;
  logic              last_grant_q;
  logic              gnt_q;
  logic              cmd_we_q;
  logic [ADDR_W-1:0] cmd_addr_q;
  logic [DATA_W-1:0] cmd_wdata_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              mem_wr_q, mem_rd_q;
  logic              r0_ack_q, r0_err_q, r1_ack_q, r1_err_q;

  logic              gnt_id, gnt_vld;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  rr_arb2 u_rr_arb2 (
    .req        ({r1_req, r0_req}),
    .last_grant (last_grant_q),
    .gnt_id     (gnt_id),
    .gnt_vld    (gnt_vld)
  );

  assign sel_we    = (gnt_id == REQ1) ? r1_we    : r0_we;
  assign sel_addr  = (gnt_id == REQ1) ? r1_addr  : r0_addr;
  assign sel_wdata = (gnt_id == REQ1) ? r1_wdata : r0_wdata;

  // Completion pulses are registered on the edge that enters RESP, so they are high exactly during RESP.
  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= REQ1;
      gnt_q        <= REQ0;
      cmd_we_q     <= 1'b0;
      cmd_addr_q   <= '0;
      cmd_wdata_q  <= '0;
      rsp_rdata_q  <= '0;
      mem_wr_q     <= 1'b0;
      mem_rd_q     <= 1'b0;
      r0_ack_q     <= 1'b0;
      r0_err_q     <= 1'b0;
      r1_ack_q     <= 1'b0;
      r1_err_q     <= 1'b0;
    end else begin
      mem_wr_q <= 1'b0;
      mem_rd_q <= 1'b0;
      r0_ack_q <= 1'b0;
      r0_err_q <= 1'b0;
      r1_ack_q <= 1'b0;
      r1_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (gnt_vld) begin
            gnt_q       <= gnt_id;
            cmd_we_q    <= sel_we;
            cmd_addr_q  <= sel_addr;
            cmd_wdata_q <= sel_wdata;
            if (sel_addr > MAX_A) begin
              r0_err_q <= (gnt_id == REQ0);
              r1_err_q <= (gnt_id == REQ1);
              state_q  <= RESP;
            end else begin
              mem_wr_q <= sel_we;
              mem_rd_q <= ~sel_we;
              state_q  <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (cmd_we_q) begin
            r0_ack_q <= (gnt_q == REQ0);
            r1_ack_q <= (gnt_q == REQ1);
            state_q  <= RESP;
          end else begin
            state_q  <= CAPTURE;
          end
        end
        CAPTURE: begin
          rsp_rdata_q <= mem_rdata;
          r0_ack_q    <= (gnt_q == REQ0) &&  mem_valid;
          r1_ack_q    <= (gnt_q == REQ1) &&  mem_valid;
          r0_err_q    <= (gnt_q == REQ0) && !mem_valid;
          r1_err_q    <= (gnt_q == REQ1) && !mem_valid;
          state_q     <= RESP;
        end
        RESP: begin
          last_grant_q <= gnt_q;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = (state_q != IDLE);
  assign mem_wr    = mem_wr_q;
  assign mem_rd    = mem_rd_q;
  assign mem_addr  = cmd_addr_q;
  assign mem_wdata = cmd_wdata_q;
  assign rsp_rdata = rsp_rdata_q;
  assign r0_ack    = r0_ack_q;
  assign r0_err    = r0_err_q;
  assign r1_ack    = r1_ack_q;
  assign r1_err    = r1_err_q;

endmodule

// File: tb/tb_mem32_arbiter.sv
// Directed bench for mem32_arbiter with a behavioural mem32 model and hand-computed expectations.
module tb_mem32_arbiter;

  logic        Clk = 1'b0;
  logic        rst_n;
  logic        r0_req, r0_we, r1_req, r1_we;
  logic [3:0]  r0_addr, r1_addr;
  logic [31:0] r0_wdata, r1_wdata;
  logic        r0_ack, r0_err, r1_ack, r1_err;
  logic [31:0] rsp_rdata;
  logic        busy, mem_wr, mem_rd;
  logic [3:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_valid;

  always #5 Clk = ~Clk;

  mem32_arbiter dut (
    .Clk       (Clk),
    .rst_n     (rst_n),
    .r0_req    (r0_req),
    .r0_we     (r0_we),
    .r0_addr   (r0_addr),
    .r0_wdata  (r0_wdata),
    .r0_ack    (r0_ack),
    .r0_err    (r0_err),
    .r1_req    (r1_req),
    .r1_we     (r1_we),
    .r1_addr   (r1_addr),
    .r1_wdata  (r1_wdata),
    .r1_ack    (r1_ack),
    .r1_err    (r1_err),
    .rsp_rdata (rsp_rdata),
    .busy      (busy),
    .mem_wr    (mem_wr),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_valid (mem_valid)
  );

  // mem32 model: byte array, read data and valid appear the cycle after the rd strobe.
  logic [7:0] mem [16];
  bit         force_invalid = 1'b0;
  int         overlap_cnt = 0;
  int         strobe_cnt = 0;

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    mem_rdata = '0;
    mem_valid = 1'b0;
  end

  always @(posedge Clk) begin
    if (mem_wr) begin
      for (int i = 0; i < 4; i++) mem[4'(mem_addr + 4'(i))] <= mem_wdata[8*i +: 8];
    end
    mem_valid <= mem_rd && !force_invalid;
    if (mem_rd) begin
      mem_rdata <= {mem[4'(mem_addr + 4'd3)], mem[4'(mem_addr + 4'd2)],
                    mem[4'(mem_addr + 4'd1)], mem[mem_addr]};
    end
  end

  always @(negedge Clk) begin
    if (mem_wr && mem_rd) overlap_cnt++;
    if (mem_wr || mem_rd) strobe_cnt++;
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic logic [31:0] ctrl_outs();
    return {25'b0, r0_ack, r0_err, r1_ack, r1_err, mem_wr, mem_rd, busy};
  endfunction

  // One transaction from an idle DUT; k values are cycle offsets from the sampling edge T (-1 = never).
  task automatic txn(input bit id, input bit we, input logic [3:0] a, input logic [31:0] wd,
                     input bit scramble, output int k_wr, output int k_rd, output int k_ack,
                     output int k_err, output bit other, output logic [31:0] rd);
    bit ack, err;
    k_wr = -1; k_rd = -1; k_ack = -1; k_err = -1; other = 1'b0; rd = '0;
    @(negedge Clk);
    if (id) begin r1_req = 1'b1; r1_we = we; r1_addr = a; r1_wdata = wd; end
    else    begin r0_req = 1'b1; r0_we = we; r0_addr = a; r0_wdata = wd; end
    for (int k = 1; k <= 20; k++) begin
      @(negedge Clk);
      if (scramble && k == 1) begin
        if (id) begin r1_we = ~we; r1_addr = ~a; r1_wdata = ~wd; end
        else    begin r0_we = ~we; r0_addr = ~a; r0_wdata = ~wd; end
      end
      if (mem_wr && k_wr < 0) k_wr = k;
      if (mem_rd && k_rd < 0) k_rd = k;
      ack = id ? r1_ack : r0_ack;
      err = id ? r1_err : r0_err;
      if (id ? (r0_ack | r0_err) : (r1_ack | r1_err)) other = 1'b1;
      if (ack) begin k_ack = k; rd = rsp_rdata; end
      if (err) k_err = k;
      if (ack || err) break;
    end
    if (id) r1_req = 1'b0; else r0_req = 1'b0;
    if (k_ack < 0 && k_err < 0) check("txn_timeout", 32'd0, 32'd1);
  endtask

  int          kw, kr, ka, ke, n, sc;
  bit          oth;
  logic [31:0] rd;
  bit          ord [8];
  int          errs;

  initial begin
    // Contention from reset: both requesters held through reset release.
    rst_n = 1'b0;
    r0_req = 1'b1; r0_we = 1'b1; r0_addr = 4'd0; r0_wdata = 32'h11111111;
    r1_req = 1'b1; r1_we = 1'b1; r1_addr = 4'd8; r1_wdata = 32'h22222222;
    repeat (2) @(negedge Clk);
    check("reset_ctrl", ctrl_outs(), 32'd0);
    check("reset_addr", {28'b0, mem_addr}, 32'd0);
    check("reset_wdata", mem_wdata, 32'd0);
    check("reset_rdata", rsp_rdata, 32'd0);
    rst_n = 1'b1;
    n = 0;
    for (int c = 0; c < 30 && n < 2; c++) begin
      @(negedge Clk);
      if (r0_ack) begin ord[n] = 1'b0; n++; r0_req = 1'b0; end
      if (r1_ack) begin ord[n] = 1'b1; n++; r1_req = 1'b0; end
    end
    r0_req = 1'b0; r1_req = 1'b0;
    check("cont_count", n, 2);
    check("cont_first", 32'(ord[0]), 32'd0);
    check("cont_second", 32'(ord[1]), 32'd1);
    txn(1'b0, 1'b0, 4'd0, 32'h0, 1'b0, kw, kr, ka, ke, oth, rd);
    check("cont_rb0", rd, 32'h11111111);
    txn(1'b1, 1'b0, 4'd8, 32'h0, 1'b0, kw, kr, ka, ke, oth, rd);
    check("cont_rb8", rd, 32'h22222222);

    // Write with inputs changed after grant, then read back.
    txn(1'b0, 1'b1, 4'd4, 32'hDEADBEEF, 1'b1, kw, kr, ka, ke, oth, rd);
    check("wr_strobe_lat", kw, 1);
    check("wr_ack_lat", ka, 2);
    check("wr_no_rd", kr, -1);
    check("wr_other", 32'(oth), 32'd0);
    txn(1'b0, 1'b0, 4'd4, 32'h0, 1'b0, kw, kr, ka, ke, oth, rd);
    check("rd_strobe_lat", kr, 1);
    check("rd_ack_lat", ka, 3);
    check("rd_data", rd, 32'hDEADBEEF);

    // Range error: no memory strobe, err at T+1, rsp_rdata untouched.
    sc = strobe_cnt;
    txn(1'b1, 1'b0, 4'd13, 32'h0, 1'b0, kw, kr, ka, ke, oth, rd);
    check("rng_err_lat", ke, 1);
    check("rng_no_ack", ka, -1);
    check("rng_no_strobe", strobe_cnt - sc, 0);
    check("rng_other", 32'(oth), 32'd0);
    check("rng_rdata_kept", rsp_rdata, 32'hDEADBEEF);

    // Fairness: both held for six transactions; last grant was r1 so r0 leads.
    @(negedge Clk);
    r0_req = 1'b1; r0_we = 1'b0; r0_addr = 4'd0;
    r1_req = 1'b1; r1_we = 1'b0; r1_addr = 4'd8;
    n = 0; errs = 0;
    for (int c = 0; c < 60 && n < 6; c++) begin
      @(negedge Clk);
      if (r0_err || r1_err) errs++;
      if (r0_ack) begin ord[n] = 1'b0; n++; end
      if (r1_ack) begin ord[n] = 1'b1; n++; end
    end
    r0_req = 1'b0; r1_req = 1'b0;
    check("fair_count", n, 6);
    check("fair_errs", errs, 0);
    for (int i = 0; i < 6; i++) check($sformatf("fair_gnt%0d", i), 32'(ord[i]), 32'(i % 2));

    // Memory reports an invalid read response.
    force_invalid = 1'b1;
    txn(1'b0, 1'b0, 4'd4, 32'h0, 1'b0, kw, kr, ka, ke, oth, rd);
    force_invalid = 1'b0;
    check("inv_err_lat", ke, 3);
    check("inv_no_ack", ka, -1);

    // Reset while a read sits in ISSUE.
    @(negedge Clk);
    r0_req = 1'b1; r0_we = 1'b0; r0_addr = 4'd4; r0_wdata = 32'h12345678;
    @(negedge Clk);
    check("rst_in_issue", 32'(mem_rd), 32'd1);
    #2 rst_n = 1'b0; r0_req = 1'b0;
    #1;
    check("rst_mid_ctrl", ctrl_outs(), 32'd0);
    check("rst_mid_addr", {28'b0, mem_addr}, 32'd0);
    check("rst_mid_wdata", mem_wdata, 32'd0);
    check("rst_mid_rdata", rsp_rdata, 32'd0);
    errs = 0;
    repeat (3) begin
      @(negedge Clk);
      if (r0_ack || r0_err || r1_ack || r1_err) errs++;
    end
    check("rst_mid_no_pulse", errs, 0);
    rst_n = 1'b1;
    txn(1'b0, 1'b0, 4'd0, 32'h0, 1'b0, kw, kr, ka, ke, oth, rd);
    check("rst_rec_lat", ka, 3);
    check("rst_rec_data", rd, 32'h11111111);

    // Boundary start address 12 is legal.
    txn(1'b1, 1'b1, 4'd12, 32'hA5A55A5A, 1'b0, kw, kr, ka, ke, oth, rd);
    check("bnd_wr_ack", ka, 2);
    check("bnd_wr_no_err", ke, -1);
    txn(1'b1, 1'b0, 4'd12, 32'h0, 1'b0, kw, kr, ka, ke, oth, rd);
    check("bnd_rd_ack", ka, 3);
    check("bnd_rd_data", rd, 32'hA5A55A5A);
    check("bnd_rd_no_err", ke, -1);

    @(negedge Clk);
    check("idle_busy", 32'(busy), 32'd0);
    check("strobe_overlap", overlap_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
